// File: rtl/icache_refill_ctrl_pkg.sv
// Shared widths, FSM encoding, tag entry layout and macro-select helper for the I-cache refill controller.
// The FLUSH state exists only when ICACHE_FENCE_I_EN is defined.
package icache_refill_ctrl_pkg;

  localparam int unsigned ADDR_WD         = 32;
  localparam int unsigned ICACHE_INDEX_WD = 7;
  localparam int unsigned OFFSET_WD       = 4;
  localparam int unsigned BEAT_WD         = 64;
  localparam int unsigned TAG_WD          = 21;
  localparam int unsigned LINE_WD         = 128;
  localparam int unsigned SRAM_DEPTH_WD   = 6;
  localparam int unsigned NUM_SETS        = 1 << ICACHE_INDEX_WD;
  localparam int unsigned NUM_MACROS      = 4;
  localparam int unsigned MACRO_SEL_WD    = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_RECV,
    ST_WRITE,
`ifdef ICACHE_FENCE_I_EN
    ST_DONE,
    ST_FLUSH
`else
    ST_DONE
`endif
  } refill_state_t;

  typedef struct packed {
    logic              valid;
    logic [TAG_WD-1:0] tag;
  } tag_entry_t;

  // Macro number: index MSB picks the macro pair, way picks within the pair.
  function automatic logic [MACRO_SEL_WD-1:0] macro_sel(input logic way,
                                                       input logic [ICACHE_INDEX_WD-1:0] index);
    return {index[ICACHE_INDEX_WD-1], way};
  endfunction

endpackage

// File: rtl/icache_refill_ctrl_lru.sv
// Per-set 1-bit LRU table: clear > refill update > hit update; combinational read port.
module icache_lru_table
  import icache_refill_ctrl_pkg::*;
(
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_clr,
  input  logic                       i_rf_we,
  input  logic [ICACHE_INDEX_WD-1:0] i_rf_index,
  input  logic                       i_rf_val,
  input  logic                       i_hit_we,
  input  logic [ICACHE_INDEX_WD-1:0] i_hit_index,
  input  logic                       i_hit_val,
  input  logic [ICACHE_INDEX_WD-1:0] i_rd_index,
  output logic                       o_rd_val_c
);

  logic [NUM_SETS-1:0] r_lru;

  // Later assignment wins, so a refill update overrides a hit to the same set.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_lru <= '0;
    end else if (i_clr) begin
      r_lru <= '0;
    end else begin
      if (i_hit_we) r_lru[i_hit_index] <= i_hit_val;
      if (i_rf_we)  r_lru[i_rf_index]  <= i_rf_val;
    end
  end

  assign o_rd_val_c = r_lru[i_rd_index];

endmodule

// File: rtl/icache_refill_ctrl.sv
// I-cache miss refill sequencer: 2-beat memory read, line assembly, SRAM/tag write, LRU victim choice.
// Optional tag-array invalidate sweep on fence_i when ICACHE_FENCE_I_EN is defined.
module icache_refill_ctrl
  import icache_refill_ctrl_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       miss_valid,
  input  logic [ADDR_WD-1:0]         miss_addr,
  input  logic                       hit_valid,
  input  logic [ICACHE_INDEX_WD-1:0] hit_index,
  input  logic                       hit_way,
`ifdef ICACHE_FENCE_I_EN
  input  logic                       fence_i,
`endif
  output logic                       busy,
  output logic                       mem_req_valid,
  input  logic                       mem_req_ready,
  output logic [ADDR_WD-1:0]         mem_req_addr,
  input  logic                       mem_resp_valid,
  input  logic [BEAT_WD-1:0]         mem_resp_data,
  input  logic                       mem_resp_last,
  output logic [NUM_MACROS-1:0]      sram_cen_n,
  output logic                       sram_wen_n,
  output logic [SRAM_DEPTH_WD-1:0]   sram_addr,
  output logic [LINE_WD-1:0]         sram_wdata,
  output logic [1:0]                 tag_we,
  output logic [ICACHE_INDEX_WD-1:0] tag_index,
  output logic [TAG_WD:0]            tag_wdata,
  output logic                       refill_done,
  output logic [LINE_WD-1:0]         refill_line
);

  localparam int unsigned FLUSH_CNT_WD = ICACHE_INDEX_WD;

  refill_state_t               r_state, w_state_nxt;
  logic [ADDR_WD-1:0]          r_addr, w_addr_nxt;
  logic                        r_victim, w_victim_nxt;
  logic                        r_beat, w_beat_nxt;
  logic [LINE_WD-1:0]          r_line, w_line_nxt;
`ifdef ICACHE_FENCE_I_EN
  logic [FLUSH_CNT_WD-1:0]     r_cnt, w_cnt_nxt;
`endif

  logic                        w_busy_nxt;
  logic                        w_mem_req_valid_nxt;
  logic [ADDR_WD-1:0]          w_mem_req_addr_nxt;
  logic [NUM_MACROS-1:0]       w_sram_cen_n_nxt;
  logic                        w_sram_wen_n_nxt;
  logic [SRAM_DEPTH_WD-1:0]    w_sram_addr_nxt;
  logic [LINE_WD-1:0]          w_sram_wdata_nxt;
  logic [1:0]                  w_tag_we_nxt;
  logic [ICACHE_INDEX_WD-1:0]  w_tag_index_nxt;
  tag_entry_t                  w_tag_entry_nxt;
  logic                        w_refill_done_nxt;
  logic [LINE_WD-1:0]          w_refill_line_nxt;

  logic [ICACHE_INDEX_WD-1:0]  w_index;
  logic [ICACHE_INDEX_WD-1:0]  w_index_nxt;
  logic [ICACHE_INDEX_WD-1:0]  w_miss_index;
  logic                        w_lru_rd;
  logic                        w_lru_clr;
  logic                        w_lru_rf_we;

  assign w_index      = r_addr[OFFSET_WD +: ICACHE_INDEX_WD];
  assign w_index_nxt  = w_addr_nxt[OFFSET_WD +: ICACHE_INDEX_WD];
  assign w_miss_index = miss_addr[OFFSET_WD +: ICACHE_INDEX_WD];
  assign w_lru_rf_we  = (r_state == ST_WRITE);

  icache_lru_table u_lru (
    .i_clk       (clk),
    .i_rst       (reset),
    .i_clr       (w_lru_clr),
    .i_rf_we     (w_lru_rf_we),
    .i_rf_index  (w_index),
    .i_rf_val    (~r_victim),
    .i_hit_we    (hit_valid),
    .i_hit_index (hit_index),
    .i_hit_val   (~hit_way),
    .i_rd_index  (w_miss_index),
    .o_rd_val_c  (w_lru_rd)
  );

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_addr   <= '0;
      r_victim <= 1'b0;
      r_beat   <= 1'b0;
      r_line   <= '0;
`ifdef ICACHE_FENCE_I_EN
      r_cnt    <= '0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_addr   <= w_addr_nxt;
      r_victim <= w_victim_nxt;
      r_beat   <= w_beat_nxt;
      r_line   <= w_line_nxt;
`ifdef ICACHE_FENCE_I_EN
      r_cnt    <= w_cnt_nxt;
`endif
    end
  end

  // Next state, datapath, and next-cycle output values (decoded from the next state).
  always_comb begin
    w_state_nxt  = r_state;
    w_addr_nxt   = r_addr;
    w_victim_nxt = r_victim;
    w_beat_nxt   = r_beat;
    w_line_nxt   = r_line;
    w_lru_clr    = 1'b0;
`ifdef ICACHE_FENCE_I_EN
    w_cnt_nxt    = r_cnt;
`endif

    case (r_state)
      ST_IDLE: begin
`ifdef ICACHE_FENCE_I_EN
        if (fence_i) begin
          w_state_nxt = ST_FLUSH;
          w_cnt_nxt   = '0;
        end else
`endif
        if (miss_valid) begin
          w_state_nxt  = ST_REQ;
          w_addr_nxt   = miss_addr;
          w_victim_nxt = w_lru_rd;
          w_beat_nxt   = 1'b0;
        end
      end
      ST_REQ: begin
        if (mem_req_ready) w_state_nxt = ST_RECV;
      end
      ST_RECV: begin
        if (mem_resp_valid) begin
          if (r_beat) w_line_nxt[LINE_WD-1:BEAT_WD] = mem_resp_data;
          else        w_line_nxt[BEAT_WD-1:0]       = mem_resp_data;
          w_beat_nxt = ~r_beat;
          if (mem_resp_last && r_beat) w_state_nxt = ST_WRITE;
        end
      end
      ST_WRITE: w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
`ifdef ICACHE_FENCE_I_EN
      ST_FLUSH: begin
        if (r_cnt == '1) begin
          w_state_nxt = ST_DONE;
          w_line_nxt  = '0;
          w_lru_clr   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + FLUSH_CNT_WD'(1);
        end
      end
`endif
      default: w_state_nxt = ST_IDLE;
    endcase

    w_mem_req_valid_nxt = 1'b0;
    w_mem_req_addr_nxt  = '0;
    w_sram_cen_n_nxt    = '1;
    w_sram_wen_n_nxt    = 1'b1;
    w_sram_addr_nxt     = '0;
    w_sram_wdata_nxt    = '0;
    w_tag_we_nxt        = '0;
    w_tag_index_nxt     = '0;
    w_tag_entry_nxt     = '0;
    w_refill_done_nxt   = 1'b0;
    w_refill_line_nxt   = '0;
    w_busy_nxt          = (w_state_nxt != ST_IDLE);

    case (w_state_nxt)
      ST_REQ: begin
        w_mem_req_valid_nxt = 1'b1;
        w_mem_req_addr_nxt  = {w_addr_nxt[ADDR_WD-1:OFFSET_WD], OFFSET_WD'(0)};
      end
      ST_WRITE: begin
        w_sram_cen_n_nxt[macro_sel(w_victim_nxt, w_index_nxt)] = 1'b0;
        w_sram_wen_n_nxt              = 1'b0;
        w_sram_addr_nxt               = w_index_nxt[SRAM_DEPTH_WD-1:0];
        w_sram_wdata_nxt              = w_line_nxt;
        w_tag_we_nxt[w_victim_nxt]    = 1'b1;
        w_tag_index_nxt               = w_index_nxt;
        w_tag_entry_nxt.valid         = 1'b1;
        w_tag_entry_nxt.tag           = w_addr_nxt[ADDR_WD-1 -: TAG_WD];
      end
      ST_DONE: begin
        w_refill_done_nxt = 1'b1;
        w_refill_line_nxt = w_line_nxt;
      end
`ifdef ICACHE_FENCE_I_EN
      ST_FLUSH: begin
        w_tag_we_nxt    = 2'b11;
        w_tag_index_nxt = w_cnt_nxt;
      end
`endif
      default: ;
    endcase
  end

  // Registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy          <= 1'b0;
      mem_req_valid <= 1'b0;
      mem_req_addr  <= '0;
      sram_cen_n    <= '1;
      sram_wen_n    <= 1'b1;
      sram_addr     <= '0;
      sram_wdata    <= '0;
      tag_we        <= '0;
      tag_index     <= '0;
      tag_wdata     <= '0;
      refill_done   <= 1'b0;
      refill_line   <= '0;
    end else begin
      busy          <= w_busy_nxt;
      mem_req_valid <= w_mem_req_valid_nxt;
      mem_req_addr  <= w_mem_req_addr_nxt;
      sram_cen_n    <= w_sram_cen_n_nxt;
      sram_wen_n    <= w_sram_wen_n_nxt;
      sram_addr     <= w_sram_addr_nxt;
      sram_wdata    <= w_sram_wdata_nxt;
      tag_we        <= w_tag_we_nxt;
      tag_index     <= w_tag_index_nxt;
      tag_wdata     <= w_tag_entry_nxt;
      refill_done   <= w_refill_done_nxt;
      refill_line   <= w_refill_line_nxt;
    end
  end

`ifndef SYNTHESIS
  // A last flag on the first beat is a memory protocol violation; the FSM keeps waiting.
  always @(posedge clk) begin
    if (!reset && r_state == ST_RECV && mem_resp_valid)
      assert (!(mem_resp_last && !r_beat))
        else $error("icache_refill_ctrl: mem_resp_last on beat 0");
  end
`endif

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Self-checking bench for icache_refill_ctrl: directed cases plus randomized refills vs. a set-level LRU model.
module tb_icache_refill_ctrl;

  logic         clk = 1'b0;
  logic         reset;
  logic         miss_valid;
  logic [31:0]  miss_addr;
  logic         hit_valid;
  logic [6:0]   hit_index;
  logic         hit_way;
`ifdef ICACHE_FENCE_I_EN
  logic         fence_i;
`endif
  logic         busy;
  logic         mem_req_valid;
  logic         mem_req_ready;
  logic [31:0]  mem_req_addr;
  logic         mem_resp_valid;
  logic [63:0]  mem_resp_data;
  logic         mem_resp_last;
  logic [3:0]   sram_cen_n;
  logic         sram_wen_n;
  logic [5:0]   sram_addr;
  logic [127:0] sram_wdata;
  logic [1:0]   tag_we;
  logic [6:0]   tag_index;
  logic [21:0]  tag_wdata;
  logic         refill_done;
  logic [127:0] refill_line;

  int n_vec = 0;
  int n_err = 0;
  bit [127:0] lru_m;

  always #5 clk = ~clk;

  icache_refill_ctrl dut (
    .clk(clk), .reset(reset),
    .miss_valid(miss_valid), .miss_addr(miss_addr),
    .hit_valid(hit_valid), .hit_index(hit_index), .hit_way(hit_way),
`ifdef ICACHE_FENCE_I_EN
    .fence_i(fence_i),
`endif
    .busy(busy),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data), .mem_resp_last(mem_resp_last),
    .sram_cen_n(sram_cen_n), .sram_wen_n(sram_wen_n), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .tag_we(tag_we), .tag_index(tag_index), .tag_wdata(tag_wdata),
    .refill_done(refill_done), .refill_line(refill_line)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_busy"}, busy, 0);
    chk({pfx, "_req_valid"}, mem_req_valid, 0);
    chk({pfx, "_req_addr"}, mem_req_addr, 0);
    chk({pfx, "_cen"}, sram_cen_n, 4'hF);
    chk({pfx, "_wen"}, sram_wen_n, 1);
    chk({pfx, "_tag_we"}, tag_we, 0);
    chk({pfx, "_done"}, refill_done, 0);
    chk({pfx, "_line"}, refill_line, 0);
  endtask

  // One-cycle compare-stage hit in a quiet cycle.
  task automatic do_hit(input logic [6:0] idx, input logic way);
    hit_valid = 1'b1; hit_index = idx; hit_way = way;
    lru_m[idx] = ~way;
    @(negedge clk);
    hit_valid = 1'b0;
  endtask

  // Full refill; expected values derived from the address, beats and the LRU model.
  task automatic do_refill(input logic [31:0] addr, input logic [63:0] d0, input logic [63:0] d1,
                           input int req_wait, input int gap0, input int gap1,
                           input bit hit_wr, input logic hit_wr_way, input bit pulse_miss);
    logic [6:0] idx;
    logic       vic;
    logic [3:0] exp_cen;
    int         lat;
    idx = addr[10:4];
    vic = lru_m[idx];
    exp_cen = 4'hF;
    exp_cen[{idx[6], vic}] = 1'b0;
    chk("idle_busy", busy, 0);
    miss_valid = 1'b1; miss_addr = addr; lat = 1;
    @(negedge clk); lat++;
    miss_valid = 1'b0; miss_addr = $urandom;
    chk("req_busy", busy, 1);
    for (int i = 0; i < req_wait; i++) begin
      chk("req_valid_wait", mem_req_valid, 1);
      chk("req_addr_wait", mem_req_addr, {addr[31:4], 4'h0});
      chk("req_cen_wait", sram_cen_n, 4'hF);
      miss_valid = (pulse_miss && i == 1);
      miss_addr  = addr ^ 32'h0000_0810;
      if ($urandom_range(0, 1) == 1) begin
        hit_valid = 1'b1; hit_index = 7'($urandom); hit_way = 1'($urandom);
        lru_m[hit_index] = ~hit_way;
      end else begin
        hit_valid = 1'b0;
      end
      @(negedge clk); lat++;
      chk("busy_wait", busy, 1);
    end
    miss_valid = 1'b0; hit_valid = 1'b0;
    chk("req_valid", mem_req_valid, 1);
    chk("req_addr", mem_req_addr, {addr[31:4], 4'h0});
    mem_req_ready = 1'b1;
    @(negedge clk); lat++;
    mem_req_ready = 1'b0;
    chk("req_drop", mem_req_valid, 0);
    for (int i = 0; i < gap0; i++) begin
      @(negedge clk); lat++;
    end
    mem_resp_valid = 1'b1; mem_resp_data = d0; mem_resp_last = 1'b0;
    @(negedge clk); lat++;
    mem_resp_valid = 1'b0;
    chk("recv_cen", sram_cen_n, 4'hF);
    for (int i = 0; i < gap1; i++) begin
      @(negedge clk); lat++;
    end
    mem_resp_valid = 1'b1; mem_resp_data = d1; mem_resp_last = 1'b1;
    @(negedge clk); lat++;
    mem_resp_valid = 1'b0; mem_resp_last = 1'b0;
    chk("wr_cen", sram_cen_n, exp_cen);
    chk("wr_wen", sram_wen_n, 0);
    chk("wr_addr", sram_addr, idx[5:0]);
    chk("wr_wdata", sram_wdata, {d1, d0});
    chk("wr_tag_we", tag_we, vic ? 2'b10 : 2'b01);
    chk("wr_tag_index", tag_index, idx);
    chk("wr_tag_wdata", tag_wdata, {1'b1, addr[31:11]});
    chk("wr_done_low", refill_done, 0);
    if (hit_wr) begin
      hit_valid = 1'b1; hit_index = idx; hit_way = hit_wr_way;
    end
    lru_m[idx] = ~vic;
    @(negedge clk); lat++;
    hit_valid = 1'b0;
    chk("done_pulse", refill_done, 1);
    chk("done_line", refill_line, {d1, d0});
    chk("done_cen", sram_cen_n, 4'hF);
    chk("done_tag_we", tag_we, 0);
    chk("latency", lat, 6 + req_wait + gap0 + gap1);
    @(negedge clk);
    chk("post_busy", busy, 0);
    chk("post_done", refill_done, 0);
    chk("post_req", mem_req_valid, 0);
  endtask

  initial begin
    reset = 1'b1; miss_valid = 1'b0; miss_addr = '0;
    hit_valid = 1'b0; hit_index = '0; hit_way = 1'b0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0; mem_resp_last = 1'b0;
`ifdef ICACHE_FENCE_I_EN
    fence_i = 1'b0;
`endif
    lru_m = '0;
    repeat (2) @(negedge clk);
    chk_reset_vals("rst");
    reset = 1'b0;
    @(negedge clk);

    // Zero-wait refills to set 4: victims 0, 1, 0.
    do_refill(32'h8000_0040, {4{16'h1111}}, {4{16'h2222}}, 0, 0, 0, 0, 0, 0);
    do_refill(32'h8000_0840, 64'hA5A5_0000_1234_5678, 64'h0F0F_F0F0_DEAD_BEEF, 0, 0, 0, 0, 0, 0);
    do_refill(32'h8000_1040, $urandom, $urandom, 0, 0, 0, 0, 0, 0);
    // Upper macro pair (index 0x44).
    do_refill(32'h8000_0440, $urandom, $urandom, 0, 0, 0, 0, 0, 0);
    // Long request stall with an ignored second miss.
    do_refill(32'h8000_0100, $urandom, $urandom, 5, 1, 2, 0, 0, 1);
    // Hit on set 4 makes way 0 the victim; a conflicting hit during WRITE loses.
    do_hit(7'h04, 1'b1);
    do_refill(32'h8000_2040, $urandom, $urandom, 0, 0, 0, 1, 1'b1, 0);
    do_refill(32'h8000_3040, $urandom, $urandom, 0, 0, 0, 0, 0, 0);
    // Hit on an unrelated set updates it normally.
    do_hit(7'h09, 1'b0);
    do_refill(32'h8000_0090, $urandom, $urandom, 1, 0, 0, 0, 0, 0);

    // Reset in RECV after beat 0; a stale beat 1 afterwards must be dropped.
    miss_valid = 1'b1; miss_addr = 32'h8000_5040;
    @(negedge clk);
    miss_valid = 1'b0; mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_data = $urandom; mem_resp_last = 1'b0;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk_reset_vals("midrst");
    lru_m = '0;
    @(negedge clk);
    reset = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_data = $urandom; mem_resp_last = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      mem_resp_valid = 1'b0; mem_resp_last = 1'b0;
      chk("stale_tag_we", tag_we, 0);
      chk("stale_cen", sram_cen_n, 4'hF);
      chk("stale_busy", busy, 0);
      chk("stale_done", refill_done, 0);
    end

`ifdef ICACHE_FENCE_I_EN
    // Invalidate sweep; a simultaneous miss loses to fence_i.
    do_hit(7'h04, 1'b0);
    fence_i = 1'b1; miss_valid = 1'b1; miss_addr = 32'h8000_0040;
    @(negedge clk);
    fence_i = 1'b0; miss_valid = 1'b0;
    for (int i = 0; i < 128; i++) begin
      chk("flush_tag_we", tag_we, 2'b11);
      chk("flush_tag_index", tag_index, 7'(i));
      chk("flush_tag_wdata", tag_wdata, 0);
      chk("flush_busy", busy, 1);
      chk("flush_req", mem_req_valid, 0);
      chk("flush_done_low", refill_done, 0);
      @(negedge clk);
    end
    chk("flush_done", refill_done, 1);
    chk("flush_line", refill_line, 0);
    chk("flush_tag_we_end", tag_we, 0);
    lru_m = '0;
    @(negedge clk);
    chk("flush_idle", busy, 0);
`endif

    // Randomized refills over a few hot sets plus random ones.
    for (int k = 0; k < 40; k++) begin
      logic [31:0] a;
      logic [6:0]  ix;
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       ix = 7'h04;
        1:       ix = 7'h44;
        2:       ix = 7'h09;
        default: ix = 7'($urandom);
      endcase
      a[10:4] = ix;
      if ($urandom_range(0, 2) == 0) do_hit(ix, 1'($urandom));
      do_refill(a, {$urandom, $urandom}, {$urandom, $urandom},
                $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 2),
                1'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
